// File: rtl/cc_pkg.sv
// Shared constants and types for the colour-correction gain sequencer.
// Channel packing everywhere is {R[23:16], G[15:8], B[7:0]}.
package cc_pkg;

  localparam int FRAC   = 8;
  localparam int GAIN_W = 8 + FRAC;

  localparam logic [GAIN_W-1:0] UNITY    = {{(GAIN_W-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
  localparam logic [GAIN_W-1:0] DIVIDEND = {8'hFF, {FRAC{1'b0}}};

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SETUP   = 3'd2,
    DIV     = 3'd3,
    DONE    = 3'd4
  } state_t;

  function automatic logic [7:0] chan_byte(input logic [23:0] v, input logic [1:0] ch);
    logic [7:0] b;
    case (ch)
      CH_R:    b = v[23:16];
      CH_G:    b = v[15:8];
      CH_B:    b = v[7:0];
      default: b = 8'd0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/cc_seq_div.sv
// Restoring unsigned divider, one quotient bit per cycle.
// quotient/last are the values produced by the current iteration, so the caller can capture on last.
module cc_seq_div #(
  parameter int GAIN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GAIN_W-1:0] dividend,
  input  logic [7:0]        divisor,
  output logic [GAIN_W-1:0] quotient,
  output logic              last
);

  localparam int CNT_W = $clog2(GAIN_W);

  logic [GAIN_W-1:0] dq_r;
  logic [7:0]        rem_r;
  logic [7:0]        divisor_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              run_r;
  logic [8:0]        rem_sh_s;
  logic [7:0]        rem_next_s;
  logic              qbit_s;

  // One restoring step; the remainder stays below the divisor so 8 bits hold it.
  always_comb begin
    rem_sh_s = {rem_r, dq_r[GAIN_W-1]};
    if (rem_sh_s >= {1'b0, divisor_r}) begin
      rem_next_s = rem_sh_s[7:0] - divisor_r;
      qbit_s     = 1'b1;
    end else begin
      rem_next_s = rem_sh_s[7:0];
      qbit_s     = 1'b0;
    end
    quotient = {dq_r[GAIN_W-2:0], qbit_s};
    last     = run_r && (cnt_r == CNT_W'(GAIN_W-1));
  end

  // Shift register holds the dividend and collects quotient bits from the bottom.
  always_ff @(posedge clk) begin
    if (rst) begin
      dq_r      <= '0;
      rem_r     <= 8'd0;
      divisor_r <= 8'd0;
      cnt_r     <= '0;
      run_r     <= 1'b0;
    end else if (start) begin
      dq_r      <= dividend;
      rem_r     <= 8'd0;
      divisor_r <= divisor;
      cnt_r     <= '0;
      run_r     <= 1'b1;
    end else if (run_r) begin
      dq_r  <= quotient;
      rem_r <= rem_next_s;
      cnt_r <= cnt_r + CNT_W'(1);
      if (last) begin
        run_r <= 1'b0;
      end else begin
        run_r <= 1'b1;
      end
    end else begin
      run_r <= 1'b0;
    end
  end

endmodule

// File: rtl/cc_gain_sequencer.sv
// Frame-level stretch-gain controller: computes R/G/B gains at end of frame with one
// shared divider and applies the whole set atomically at the next start-of-frame.
module cc_gain_sequencer
  import cc_pkg::*;
#(
  parameter int FRAC   = 8,
  parameter int GAIN_W = 8 + FRAC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stats_valid,
  input  logic [23:0]       stats_min,
  input  logic [23:0]       stats_max,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tuser,
  output logic [GAIN_W-1:0] gain_r,
  output logic [GAIN_W-1:0] gain_g,
  output logic [GAIN_W-1:0] gain_b,
  output logic [23:0]       offset,
  output logic              coef_update,
  output logic              busy,
  output logic              pending,
  output logic              overrun
);

  localparam logic [GAIN_W-1:0] UNITY_P    = {{(GAIN_W-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
  localparam logic [GAIN_W-1:0] DIVIDEND_P = {8'hFF, {FRAC{1'b0}}};

  state_t            state_r;
  logic [1:0]        ch_r;
  logic [23:0]       min_r;
  logic [23:0]       max_r;
  logic [GAIN_W-1:0] pgain_r [3];
  logic [7:0]        poff_r  [3];

  logic              frame_start_s;
  logic              apply_s;
  logic [7:0]        cur_min_s;
  logic [7:0]        cur_max_s;
  logic              flat_s;
  logic [7:0]        range_s;
  logic              div_start_s;
  logic [GAIN_W-1:0] div_q_s;
  logic              div_last_s;

  // Current-channel operands; a flat channel still runs the divider so latency is constant.
  always_comb begin
    frame_start_s = s_axis_tvalid & s_axis_tuser;
    apply_s       = frame_start_s && pending && ((state_r == IDLE) || (state_r == DONE));
    cur_min_s     = chan_byte(min_r, ch_r);
    cur_max_s     = chan_byte(max_r, ch_r);
    flat_s        = (cur_max_s <= cur_min_s);
    range_s       = cur_max_s - cur_min_s;
    div_start_s   = (state_r == SETUP);
  end

  cc_seq_div #(.GAIN_W(GAIN_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start_s),
    .dividend (DIVIDEND_P),
    .divisor  (range_s),
    .quotient (div_q_s),
    .last     (div_last_s)
  );

  // Sequencer FSM with pending/active coefficient banks and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      ch_r        <= CH_R;
      min_r       <= 24'd0;
      max_r       <= 24'd0;
      for (int i = 0; i < 3; i++) begin
        pgain_r[i] <= UNITY_P;
        poff_r[i]  <= 8'd0;
      end
      gain_r      <= UNITY_P;
      gain_g      <= UNITY_P;
      gain_b      <= UNITY_P;
      offset      <= 24'd0;
      coef_update <= 1'b0;
      busy        <= 1'b0;
      pending     <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      coef_update <= 1'b0;
      // Apply first so a same-cycle capture cannot clobber the set being applied.
      if (apply_s) begin
        gain_r      <= pgain_r[0];
        gain_g      <= pgain_r[1];
        gain_b      <= pgain_r[2];
        offset      <= {poff_r[0], poff_r[1], poff_r[2]};
        pending     <= 1'b0;
        coef_update <= 1'b1;
      end
      if (stats_valid && (state_r != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (stats_valid) begin
            min_r   <= stats_min;
            max_r   <= stats_max;
            ch_r    <= CH_R;
            pending <= 1'b0;
            busy    <= 1'b1;
            state_r <= CAPTURE;
          end
        end
        CAPTURE: state_r <= SETUP;
        SETUP:   state_r <= DIV;
        DIV: begin
          if (div_last_s) begin
            pgain_r[ch_r] <= flat_s ? UNITY_P : div_q_s;
            poff_r[ch_r]  <= flat_s ? 8'd0 : cur_min_s;
            if (ch_r == CH_B) begin
              pending <= 1'b1;
              busy    <= 1'b0;
              state_r <= DONE;
            end else begin
              ch_r    <= ch_r + 2'd1;
              state_r <= SETUP;
            end
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cc_gain_sequencer.sv
// Randomised and directed bench for cc_gain_sequencer against a cycle-count reference model.
module tb_cc_gain_sequencer;

  localparam int FRAC   = 8;
  localparam int GAIN_W = 16;
  localparam int LAT    = 53;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stats_valid = 1'b0;
  logic [23:0]       stats_min = 24'd0;
  logic [23:0]       stats_max = 24'd0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tuser = 1'b0;
  logic [GAIN_W-1:0] gain_r, gain_g, gain_b;
  logic [23:0]       offset;
  logic              coef_update, busy, pending, overrun;

  always #5 clk = ~clk;

  cc_gain_sequencer #(.FRAC(FRAC), .GAIN_W(GAIN_W)) dut (
    .clk(clk), .rst(rst), .stats_valid(stats_valid), .stats_min(stats_min),
    .stats_max(stats_max), .s_axis_tvalid(s_axis_tvalid), .s_axis_tuser(s_axis_tuser),
    .gain_r(gain_r), .gain_g(gain_g), .gain_b(gain_b), .offset(offset),
    .coef_update(coef_update), .busy(busy), .pending(pending), .overrun(overrun)
  );

  // Reference model: age counts cycles since stats were accepted (-1 = idle).
  int          age = -1;
  logic        m_pend = 1'b0, m_ovr = 1'b0, m_cu = 1'b0;
  logic [15:0] m_gain [3];
  logic [15:0] m_pgain [3];
  logic [15:0] m_cgain [3];
  logic [23:0] m_off = 24'd0, m_poff = 24'd0, m_coff = 24'd0;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic calc(input logic [23:0] mn, input logic [23:0] mx);
    m_coff = 24'd0;
    for (int c = 0; c < 3; c++) begin
      int lo, hi;
      lo = (mn >> (16 - 8 * c)) & 255;
      hi = (mx >> (16 - 8 * c)) & 255;
      if (hi > lo) begin
        m_cgain[c] = 16'((255 * 256) / (hi - lo));
        m_coff     = m_coff | (24'(lo) << (16 - 8 * c));
      end else begin
        m_cgain[c] = 16'd256;
      end
    end
  endtask

  task automatic model_edge();
    bit fs;
    fs   = s_axis_tvalid && s_axis_tuser;
    m_cu = 1'b0;
    if (rst) begin
      age = -1; m_pend = 1'b0; m_ovr = 1'b0; m_off = 24'd0; m_poff = 24'd0;
      for (int c = 0; c < 3; c++) begin
        m_gain[c] = 16'd256;
        m_pgain[c] = 16'd256;
      end
    end else begin
      if (fs && m_pend && (age == -1 || age == LAT)) begin
        m_gain = m_pgain; m_off = m_poff; m_pend = 1'b0; m_cu = 1'b1;
      end
      if (stats_valid && age == -1) begin
        calc(stats_min, stats_max);
        m_pend = 1'b0;
        age = 1;
      end else begin
        if (stats_valid) m_ovr = 1'b1;
        if (age == LAT) begin
          age = -1;
        end else if (age >= 1) begin
          age++;
          if (age == LAT) begin
            m_pend = 1'b1; m_pgain = m_cgain; m_poff = m_coff;
          end
        end
      end
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("gain_r", 32'(gain_r), 32'(m_gain[0]));
      chk("gain_g", 32'(gain_g), 32'(m_gain[1]));
      chk("gain_b", 32'(gain_b), 32'(m_gain[2]));
      chk("offset", 32'(offset), 32'(m_off));
      chk("coef_update", 32'(coef_update), 32'(m_cu));
      chk("busy", 32'(busy), 32'(age >= 1 && age < LAT));
      chk("pending", 32'(pending), 32'(m_pend));
      chk("overrun", 32'(overrun), 32'(m_ovr));
    end
  end

  task automatic step(input bit sv, input logic [23:0] mn, input logic [23:0] mx,
                      input bit tv, input bit tu, input bit r);
    rst = r; stats_valid = sv; stats_min = mn; stats_max = mx;
    s_axis_tvalid = tv; s_axis_tuser = tu;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 24'd0, 24'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic stats(input logic [23:0] mn, input logic [23:0] mx);
    step(1'b1, mn, mx, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fstart();
    step(1'b0, 24'd0, 24'd0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    step(1'b0, 24'd0, 24'd0, 1'b0, 1'b0, 1'b1);
    cmp_en = 1'b1;
    step(1'b0, 24'd0, 24'd0, 1'b0, 1'b0, 1'b1);
    chk("lit_reset_gain", 32'(gain_r), 32'd256);
    chk("lit_reset_off", 32'(offset), 32'd0);
    chk("lit_reset_flags", {busy, pending, overrun}, 32'd0);

    // Basic stretch, exact latency, then apply.
    stats(24'h100064, 24'hFFFF64);
    idle(LAT - 2);
    chk("lit_pending_early", 32'(pending), 32'd0);
    chk("lit_busy_last", 32'(busy), 32'd1);
    idle(1);
    chk("lit_pending_53", 32'(pending), 32'd1);
    chk("lit_not_active", 32'(gain_r), 32'd256);
    fstart();
    chk("lit_gain_r", 32'(gain_r), 32'd273);
    chk("lit_gain_gb", {gain_g, gain_b}, {16'd256, 16'd256});
    chk("lit_offset", 32'(offset), 32'h100000);
    chk("lit_coef_update", 32'(coef_update), 32'd1);
    idle(1);
    chk("lit_coef_update_pulse", 32'(coef_update), 32'd0);

    // Empty frame.
    stats(24'hFFFFFF, 24'h000000);
    idle(LAT + 2);
    fstart();
    chk("lit_empty_gain", 32'(gain_r), 32'd256);
    chk("lit_empty_off", 32'(offset), 32'd0);

    // frame_start mid-computation is ignored.
    stats(24'h204060, 24'hA0C0E0);
    idle(19);
    fstart();
    chk("lit_fs_busy_ignored", 32'(coef_update), 32'd0);
    idle(LAT);
    fstart();
    chk("lit_fs_gain", 32'(gain_g), 32'd510);
    chk("lit_fs_off", 32'(offset), 32'h204060);

    // stats_valid while busy is dropped and flagged.
    stats(24'h000010, 24'hFF8011);
    idle(9);
    stats(24'h000000, 24'h0A0A0A);
    chk("lit_overrun", 32'(overrun), 32'd1);
    idle(LAT + 3);

    // Simultaneous capture and apply, then reset mid-computation.
    step(1'b1, 24'h010203, 24'h050607, 1'b1, 1'b1, 1'b0);
    chk("lit_simul_b", 32'(gain_b), 32'hFF00);
    chk("lit_simul_g", 32'(gain_g), 32'd510);
    chk("lit_simul_busy", 32'(busy), 32'd1);
    idle(29);
    step(1'b0, 24'd0, 24'd0, 1'b0, 1'b0, 1'b1);
    chk("lit_rst_gain", 32'(gain_b), 32'd256);
    chk("lit_rst_flags", {coef_update, busy, pending, overrun}, 32'd0);
    idle(LAT + 2);
    chk("lit_rst_no_pending", 32'(pending), 32'd0);

    // Random phase.
    for (int i = 0; i < 4000; i++) begin
      logic [23:0] mn, mx;
      mn = 24'($urandom);
      mx = ($urandom_range(0, 3) == 0) ? mn : 24'($urandom);
      step($urandom_range(0, 39) == 0, mn, mx, $urandom_range(0, 1) == 1,
           $urandom_range(0, 5) == 0, $urandom_range(0, 1999) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
